// File: rtl/sm_motor_pwm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sm_motor_pwm : rate-limited H-bridge PWM drive, one motor per instance.    |
// | Optional macro SM_PWM_BRAKE_EN: short-brake in STOP.     Rev 1.0           |
// +----------------------------------------------------------------------------+
module sm_motor_pwm #(
   parameter int PRESCALE  = 8,
   parameter int RAMP_STEP = 4
) (
   input  logic       clk_50,
   input  logic       rst_n,
   input  logic [7:0] speed,
   input  logic       dir,
   input  logic       enable,
   output logic       pwm_a,
   output logic       pwm_b,
   output logic [7:0] duty_now,
   output logic       period_tick,
   output logic [1:0] state
);
   localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
   localparam logic [8:0]    STEP9   = 9'(RAMP_STEP);

   typedef enum logic [1:0] {
      ST_STOP    = 2'd0,
      ST_RUN     = 2'd1,
      ST_REVERSE = 2'd2
   } state_t;

   state_t        st, st_next;
   logic [PW-1:0] pre;
   logic [7:0]    cnt;
   logic          dir_applied;
   logic          step, boundary;
   logic          dir_mismatch, swap, on, brake;
   logic [7:0]    target, duty_next;
   logic [8:0]    diff_up, diff_dn;

   assign step         = (pre == PRE_MAX);
   assign boundary     = step && (cnt == 8'hFF);
   assign dir_mismatch = (dir != dir_applied);
   assign swap         = dir_mismatch && (duty_now == 8'd0);
   assign target       = (!enable || dir_mismatch) ? 8'd0 : speed;
   assign diff_up      = {1'b0, target} - {1'b0, duty_now};
   assign diff_dn      = {1'b0, duty_now} - {1'b0, target};
   assign on           = (cnt < duty_now);
   assign state        = st;

   // Differences are only used in the branch where they are positive.
   always_comb begin
      duty_next = duty_now;
      if (target > duty_now)
         duty_next = (diff_up > STEP9) ? duty_now + STEP9[7:0] : target;
      else if (target < duty_now)
         duty_next = (diff_dn > STEP9) ? duty_now - STEP9[7:0] : target;
   end

   always_comb begin
      st_next = st;
      case (st)
         ST_STOP: begin
            if (target != 8'd0)
               st_next = ST_RUN;
         end
         ST_RUN: begin
            if (dir_mismatch && (duty_now != 8'd0))
               st_next = ST_REVERSE;
            else if (!enable && (duty_next == 8'd0))
               st_next = ST_STOP;
         end
         ST_REVERSE: begin
            if (swap)
               st_next = enable ? ST_RUN : ST_STOP;
            else if (!dir_mismatch)
               st_next = ST_RUN;
         end
         default: st_next = ST_STOP;
      endcase
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         pre         <= '0;
         cnt         <= 8'd0;
         duty_now    <= 8'd0;
         dir_applied <= 1'b0;
         st          <= ST_STOP;
         period_tick <= 1'b0;
      end else begin
         pre         <= step ? '0 : pre + 1'b1;
         period_tick <= boundary;
         if (step)
            cnt <= cnt + 8'd1;
         if (boundary) begin
            duty_now <= duty_next;
            st       <= st_next;
            if (swap)
               dir_applied <= dir;
         end
      end
   end

`ifdef SM_PWM_BRAKE_EN
   logic en_s;

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n)
         en_s <= 1'b0;
      else if (boundary)
         en_s <= enable;
   end

   assign brake = (st == ST_STOP) && !en_s && (duty_now == 8'd0);
`else
   assign brake = 1'b0;
`endif

   // Compare output is registered, so bridge edges lag the count by one cycle.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         pwm_a <= 1'b0;
         pwm_b <= 1'b0;
      end else begin
         pwm_a <= brake | (on & ~dir_applied);
         pwm_b <= brake | (on &  dir_applied);
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_sm_motor_pwm.sv
`default_nettype none
// Directed bench for sm_motor_pwm at PRESCALE=1, RAMP_STEP=4.
module tb_sm_motor_pwm;
   logic       clk_50 = 1'b0;
   logic       rst_n;
   logic [7:0] speed;
   logic       dir;
   logic       enable;
   logic       pwm_a, pwm_b, period_tick;
   logic [7:0] duty_now;
   logic [1:0] state;

   int vectors     = 0;
   int miscompares = 0;
   int exp_duty    = 0;

   bit chk_overlap = 1'b0, chk_no_a = 1'b0, chk_no_b = 1'b0;
   int viol_overlap = 0, viol_a = 0, viol_b = 0;

   sm_motor_pwm #(.PRESCALE(1), .RAMP_STEP(4)) dut (
      .clk_50     (clk_50),
      .rst_n      (rst_n),
      .speed      (speed),
      .dir        (dir),
      .enable     (enable),
      .pwm_a      (pwm_a),
      .pwm_b      (pwm_b),
      .duty_now   (duty_now),
      .period_tick(period_tick),
      .state      (state)
   );

   always #5 clk_50 = ~clk_50;

   always @(negedge clk_50) begin
      if (rst_n) begin
         if (chk_overlap && pwm_a && pwm_b) viol_overlap++;
         if (chk_no_a && pwm_a) viol_a++;
         if (chk_no_b && pwm_b) viol_b++;
      end
   end

   task automatic wait_tick(output bit ok);
      int n = 0;
      do begin
         @(negedge clk_50);
         n++;
      end while (!period_tick && n < 400);
      ok = period_tick;
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL tick_timeout: no period_tick within %0d cycles", n);
      end
   endtask

   // Advances nper periods, stepping the reference duty toward tgt by at most 4.
   task automatic run_periods(input int tgt, input int nper, input string tag);
      bit ok;
      for (int k = 0; k < nper; k++) begin
         if (tgt > exp_duty)      exp_duty += (tgt - exp_duty > 4) ? 4 : tgt - exp_duty;
         else if (tgt < exp_duty) exp_duty -= (exp_duty - tgt > 4) ? 4 : exp_duty - tgt;
         wait_tick(ok);
         vectors++;
         if (duty_now !== 8'(exp_duty)) begin
            miscompares++;
            $display("FAIL %s period %0d: duty_now=%0d expected %0d", tag, k, duty_now, exp_duty);
         end
      end
   endtask

   // Samples one full period starting at the current negedge.
   task automatic count_high(output int na, output int nb);
      na = 0;
      nb = 0;
      for (int i = 0; i < 256; i++) begin
         if (i != 0) @(negedge clk_50);
         if (pwm_a) na++;
         if (pwm_b) nb++;
      end
   endtask

   task automatic test_reset;
      bit ok;
      int n;
      rst_n = 1'b0; enable = 1'b0; speed = 8'd0; dir = 1'b0;
      repeat (3) @(negedge clk_50);
      vectors++;
      if ({pwm_a, pwm_b, period_tick} !== 3'b000 || duty_now !== 8'd0 || state !== 2'd0) begin
         miscompares++;
         $display("FAIL reset: a=%b b=%b tick=%b duty=%0d state=%0d expected 0 0 0 0 0",
                  pwm_a, pwm_b, period_tick, duty_now, state);
      end
      rst_n = 1'b1;
      wait_tick(ok);
      n = 0;
      do begin
         @(negedge clk_50);
         n++;
      end while (!period_tick && n < 400);
      vectors++;
      if (n != 256) begin
         miscompares++;
         $display("FAIL tick_period: got %0d cycles expected 256", n);
      end
   endtask

   task automatic test_ramp_up;
      int na, nb;
      enable = 1'b1; speed = 8'd100; dir = 1'b0;
      run_periods(100, 25, "ramp_up");
      run_periods(100, 1, "hold100");
      vectors++;
      if (state !== 2'd1) begin
         miscompares++;
         $display("FAIL run_state: state=%0d expected 1", state);
      end
      chk_overlap = 1'b1;
      count_high(na, nb);
      vectors++;
      if (na != 100 || nb != 0) begin
         miscompares++;
         $display("FAIL duty100_high: a_high=%0d b_high=%0d expected 100 0", na, nb);
      end
   endtask

   task automatic test_speed_change;
      bit ok;
      int na, nb;
      wait_tick(ok);
      repeat (50) @(negedge clk_50);
      speed = 8'd98;
      repeat (20) @(negedge clk_50);
      vectors++;
      if (duty_now !== 8'd100) begin
         miscompares++;
         $display("FAIL midperiod_hold: duty_now=%0d expected 100", duty_now);
      end
      run_periods(98, 1, "down_to_98");
      speed = 8'd255;
      run_periods(255, 40, "up_to_255");
      run_periods(255, 1, "hold255");
      count_high(na, nb);
      vectors++;
      if (na != 255 || nb != 0) begin
         miscompares++;
         $display("FAIL duty255_high: a_high=%0d b_high=%0d expected 255 0", na, nb);
      end
      speed = 8'd100;
      run_periods(100, 39, "down_to_100");
      run_periods(100, 1, "hold100b");
   endtask

   task automatic test_reverse;
      bit ok;
      int na, nb;
      chk_no_b = 1'b1;
      repeat (30) @(negedge clk_50);
      dir = 1'b1;
      run_periods(0, 1, "rev_first");
      vectors++;
      if (state !== 2'd2) begin
         miscompares++;
         $display("FAIL rev_state: state=%0d expected 2", state);
      end
      run_periods(0, 24, "rev_decel");
      wait_tick(ok);
      vectors++;
      if (state !== 2'd1 || duty_now !== 8'd0) begin
         miscompares++;
         $display("FAIL rev_swap: state=%0d duty=%0d expected 1 0", state, duty_now);
      end
      chk_no_b = 1'b0;
      chk_no_a = 1'b1;
      run_periods(100, 25, "rev_accel");
      count_high(na, nb);
      vectors++;
      if (na != 0 || nb != 100) begin
         miscompares++;
         $display("FAIL rev_high: a_high=%0d b_high=%0d expected 0 100", na, nb);
      end
      vectors++;
      if (viol_a != 0 || viol_b != 0 || viol_overlap != 0) begin
         miscompares++;
         $display("FAIL exclusivity: a_viol=%0d b_viol=%0d both=%0d expected 0 0 0",
                  viol_a, viol_b, viol_overlap);
      end
      chk_no_a = 1'b0;
   endtask

   task automatic test_stop;
`ifdef SM_PWM_BRAKE_EN
      chk_overlap = 1'b0;
`endif
      repeat (40) @(negedge clk_50);
      enable = 1'b0;
      run_periods(0, 25, "stop_decel");
      vectors++;
      if (state !== 2'd0) begin
         miscompares++;
         $display("FAIL stop_state: state=%0d expected 0", state);
      end
      repeat (5) @(negedge clk_50);
      vectors++;
`ifdef SM_PWM_BRAKE_EN
      if ({pwm_a, pwm_b} !== 2'b11) begin
         miscompares++;
         $display("FAIL stop_outputs: a=%b b=%b expected 1 1", pwm_a, pwm_b);
      end
`else
      if ({pwm_a, pwm_b} !== 2'b00) begin
         miscompares++;
         $display("FAIL stop_outputs: a=%b b=%b expected 0 0", pwm_a, pwm_b);
      end
`endif
   endtask

   task automatic test_async_reset;
      bit ok;
      repeat (10) @(negedge clk_50);
      dir = 1'b0; enable = 1'b1; speed = 8'd100;
      wait_tick(ok);
      vectors++;
      if (state !== 2'd0 || duty_now !== 8'd0) begin
         miscompares++;
         $display("FAIL stop_swap: state=%0d duty=%0d expected 0 0", state, duty_now);
      end
      run_periods(100, 5, "restart_a");
      @(negedge clk_50);
      vectors++;
      if (pwm_a !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_a: pwm_a=%b expected 1", pwm_a);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (pwm_a !== 1'b0 || duty_now !== 8'd0 || state !== 2'd0) begin
         miscompares++;
         $display("FAIL async_reset: a=%b duty=%0d state=%0d expected 0 0 0", pwm_a, duty_now, state);
      end
      @(negedge clk_50);
      rst_n = 1'b1;
      exp_duty = 0;
      run_periods(100, 1, "post_reset");
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_speed_change();
      test_reverse();
      test_stop();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
